// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    // Per-cycle scan state: dark, anti-ghost blank window, or driving a digit
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 32;

    // All anodes released; callers slice it down to their own digit count
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/ssd_refresh_timer.sv
// Slot timer: counts cycles within a digit slot and steps the selected digit.
// wrap is high on the cycle whose closing edge takes sel back to slot 0.
module ssd_refresh_timer
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int CW          = $clog2(REFRESH_DIV),
    parameter int SW          = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic [SW-1:0] sel,
    output logic          wrap
);

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sel_q, sel_d;

    // Next count/slot; a disabled scan is parked at slot 0, count 0
    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        wrap  = 1'b0;
        if (!en) begin
            cnt_d = '0;
            sel_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (sel_q == SEL_LAST) begin
                sel_d = '0;
                wrap  = 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign cnt = cnt_q;
    assign sel = sel_q;

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexes NUM_DIGITS hex digits onto a common-anode display with
// frame-coherent latching, leading-zero blanking and a per-slot blank window.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic                           blank_lz,
    output logic [NUM_DIGITS-1:0]          anode_n,
    output logic [NIBBLE_W-1:0]            digit,
    output logic                           dp_n,
    output logic                           frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = ANODE_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
    localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [SW-1:0] sel;
    logic          wrap;

    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]               shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]               suppress;
    scan_state_t                         state;

    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [NIBBLE_W-1:0]   digit_q, digit_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_tick_q, frame_tick_d;

    ssd_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cnt   (cnt),
        .sel   (sel),
        .wrap  (wrap)
    );

    // Shadow captures inputs only at frame wrap (no tearing) or while idle
    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        if (wrap || !en) begin
            shadow_dig_d = digits_in;
            shadow_dp_d  = dp_in;
        end
    end

    // Shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    // Digit i is a leading zero when it and every digit above it is 0 with no dp
    always_comb begin
        logic all_zero;
        suppress = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (shadow_dig_q[i] == '0) && !shadow_dp_q[i];
            suppress[i] = blank_lz && all_zero;
        end
    end

    // Scan state is a pure function of this cycle's enable and slot count;
    // the counter is parked at 0 while disabled, so re-enable always enters BLANK
    always_comb begin
        state = OFF;
        if (en) state = (cnt < BLANK_END) ? BLANK : DRIVE;
    end

    // Output decode: drive the selected anode only in DRIVE and when not blanked
    always_comb begin
        anode_d      = AN_OFF;
        digit_d      = digit_q;
        dp_n_d       = 1'b1;
        frame_tick_d = wrap;
        if (state == DRIVE && !suppress[sel]) begin
            anode_d = ~(AN_ONE << sel);
            digit_d = shadow_dig_q[sel];
            dp_n_d  = ~shadow_dp_q[sel];
        end
    end

    // Output registers; async reset darkens the display immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q      <= AN_OFF;
            digit_q      <= '0;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            anode_q      <= anode_d;
            digit_q      <= digit_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode_n    = anode_q;
    assign digit      = digit_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller (4 digits, 8-cycle slots, 2 blank cycles).
module tb_ssd_scan_controller;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    anode_n;
    logic [3:0]    digit;
    logic          dp_n;
    logic          frame_tick;

    ssd_scan_controller #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .anode_n    (anode_n),
        .digit      (digit),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] dig;
        logic       dpn;
        logic       tick;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] cap_an[$];
    logic [3:0] cap_dig[$];
    logic       cap_dpn[$];
    logic       cap_tick[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: time position within the scan plus the latched frame
    int          m_cnt;
    int          m_sel;
    logic [15:0] m_sh_dig;
    logic [3:0]  m_sh_dp;
    logic [3:0]  m_dig;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_sel    = 0;
        m_sh_dig = '0;
        m_sh_dp  = '0;
        m_dig    = '0;
        sb.delete();
    endtask

    task automatic cap_clear();
        cap_an.delete();
        cap_dig.delete();
        cap_dpn.delete();
        cap_tick.delete();
    endtask

    // One clock: predict the registered outputs from the pre-edge cycle, push,
    // then pop and compare once the DUT has clocked them out.
    task automatic step();
        exp_t e, g;
        logic lit, upper_zero;
        lit = 1'b0;
        if (en && m_cnt >= BLK) begin
            upper_zero = 1'b1;
            for (int j = m_sel; j < ND; j++)
                if (m_sh_dig[j*4 +: 4] != 4'h0 || m_sh_dp[j]) upper_zero = 1'b0;
            lit = !(blank_lz && m_sel != 0 && upper_zero);
        end
        if (lit) m_dig = m_sh_dig[m_sel*4 +: 4];
        e.an   = lit ? ~(4'b0001 << m_sel) : 4'b1111;
        e.dig  = m_dig;
        e.dpn  = lit ? ~m_sh_dp[m_sel] : 1'b1;
        e.tick = en && m_cnt == DIV - 1 && m_sel == ND - 1;
        if (!en) begin
            m_cnt = 0; m_sel = 0; m_sh_dig = digits_in; m_sh_dp = dp_in;
        end else if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            if (m_sel == ND - 1) begin
                m_sel = 0; m_sh_dig = digits_in; m_sh_dp = dp_in;
            end else begin
                m_sel++;
            end
        end else begin
            m_cnt++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("anode_n", anode_n, g.an);
        chk("digit", digit, g.dig);
        chk("dp_n", dp_n, g.dpn);
        chk("frame_tick", frame_tick, g.tick);
        chk("one_hot", ($countones(~anode_n) <= 1), 1);
        cap_an.push_back(anode_n);
        cap_dig.push_back(digit);
        cap_dpn.push_back(dp_n);
        cap_tick.push_back(frame_tick);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Idle two cycles (latching current inputs), then start a fresh frame
    task automatic restart();
        en = 1'b0;
        steps(2);
        en = 1'b1;
        cap_clear();
    endtask

    // Directed check of a captured sample against literal expectations
    task automatic chk_cap(input string tag, input int idx, input logic [3:0] an,
                           input logic [3:0] dig, input logic dpn);
        chk({tag, ".an"}, cap_an[idx], an);
        chk({tag, ".dig"}, cap_dig[idx], dig);
        chk({tag, ".dpn"}, cap_dpn[idx], dpn);
    endtask

    initial begin
        int ticks;
        rst_n     = 1'b0;
        en        = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        model_reset();

        // Reset values
        #12;
        chk("rst.anode_n", anode_n, 4'b1111);
        chk("rst.digit", digit, 4'h0);
        chk("rst.dp_n", dp_n, 1'b1);
        chk("rst.frame_tick", frame_tick, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic scan of 1234
        digits_in = 16'h1234;
        step();
        en = 1'b1;
        cap_clear();
        steps(32);
        chk_cap("scan.s0_blank", 1, 4'b1111, 4'h0, 1'b1);
        chk_cap("scan.s0_first", 2, 4'b1110, 4'h4, 1'b1);
        chk_cap("scan.s0", 7, 4'b1110, 4'h4, 1'b1);
        chk_cap("scan.s1_blank", 9, 4'b1111, 4'h4, 1'b1);
        chk_cap("scan.s1", 15, 4'b1101, 4'h3, 1'b1);
        chk_cap("scan.s2", 23, 4'b1011, 4'h2, 1'b1);
        chk_cap("scan.s3", 31, 4'b0111, 4'h1, 1'b1);
        ticks = 0;
        for (int k = 0; k < 31; k++) ticks += int'(cap_tick[k]);
        chk("scan.tick_early", ticks, 0);
        chk("scan.tick_wrap", cap_tick[31], 1'b1);

        // Tearing: change inputs during slot 2
        cap_clear();
        steps(19);
        digits_in = 16'h5678;
        steps(13);
        steps(32);
        chk_cap("tear.s2_old", 23, 4'b1011, 4'h2, 1'b1);
        chk_cap("tear.s3_old", 31, 4'b0111, 4'h1, 1'b1);
        chk_cap("tear.s0_new", 39, 4'b1110, 4'h8, 1'b1);
        chk_cap("tear.s1_new", 47, 4'b1101, 4'h7, 1'b1);
        chk_cap("tear.s2_new", 55, 4'b1011, 4'h6, 1'b1);
        chk_cap("tear.s3_new", 63, 4'b0111, 4'h5, 1'b1);

        // Leading-zero blanking
        blank_lz  = 1'b1;
        digits_in = 16'h0070;
        restart();
        steps(32);
        chk_cap("lz70.s0", 7, 4'b1110, 4'h0, 1'b1);
        chk_cap("lz70.s1", 15, 4'b1101, 4'h7, 1'b1);
        chk("lz70.s2", cap_an[23], 4'b1111);
        chk("lz70.s3", cap_an[31], 4'b1111);

        digits_in = 16'h0000;
        restart();
        steps(32);
        chk_cap("lz00.s0", 7, 4'b1110, 4'h0, 1'b1);
        chk("lz00.s1", cap_an[15], 4'b1111);
        chk("lz00.s2", cap_an[23], 4'b1111);
        chk("lz00.s3", cap_an[31], 4'b1111);

        // Decimal point stops blanking at its digit
        digits_in = 16'h0005;
        dp_in     = 4'b0100;
        restart();
        steps(32);
        chk_cap("lzdp.s0", 7, 4'b1110, 4'h5, 1'b1);
        chk_cap("lzdp.s1", 15, 4'b1101, 4'h0, 1'b1);
        chk_cap("lzdp.s2", 23, 4'b1011, 4'h0, 1'b0);
        chk("lzdp.s3", cap_an[31], 4'b1111);

        // Disable mid-slot, then re-enable with new data
        blank_lz  = 1'b0;
        dp_in     = 4'b0000;
        digits_in = 16'h1234;
        restart();
        steps(21);
        chk("dis.pre_lit", cap_an[20], 4'b1011);
        en = 1'b0;
        steps(2);
        chk("dis.dark1", cap_an[21], 4'b1111);
        chk("dis.dark2", cap_an[22], 4'b1111);
        digits_in = 16'h9abc;
        steps(3);
        en = 1'b1;
        cap_clear();
        steps(35);
        chk("reen.blank", cap_an[1], 4'b1111);
        chk_cap("reen.s0_first", 2, 4'b1110, 4'hc, 1'b1);
        chk_cap("reen.s1", 15, 4'b1101, 4'hb, 1'b1);
        chk_cap("reen.s3", 31, 4'b0111, 4'h9, 1'b1);
        chk_cap("reen.lit", 34, 4'b1110, 4'hc, 1'b1);

        // Async reset while driving: outputs dark before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.anode_n", anode_n, 4'b1111);
        chk("arst.digit", digit, 4'h0);
        chk("arst.dp_n", dp_n, 1'b1);
        chk("arst.frame_tick", frame_tick, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst.hold", anode_n, 4'b1111);
        rst_n = 1'b1;
        cap_clear();
        steps(40);
        chk_cap("arst.zero_shadow", 7, 4'b1110, 4'h0, 1'b1);
        chk_cap("arst.relatched", 39, 4'b1110, 4'hc, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
